// File: rtl/baudrate_clk_gen.sv
// Baud-rate clock generator for the UART receive path: divides clk down to one bit period while en is high.
// Build option BAUDRATE_CLK_GEN_MIDBIT_EN places the first tick at mid-start-bit instead of one full period after enable.
module baudrate_clk_gen #(
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic baud_clk,
    output logic baud_tick
);

    localparam int DIV  = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int HALF = DIV / 2;
`ifdef BAUDRATE_CLK_GEN_MIDBIT_EN
    localparam int FIRST = HALF;
`else
    localparam int FIRST = DIV;
`endif
    // The count runs 1..DIV, so the width must hold DIV itself.
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV + 1);

    localparam logic [CW-1:0] C_DIV   = CW'(DIV);
    localparam logic [CW-1:0] C_HALF  = CW'(HALF);
    localparam logic [CW-1:0] C_FIRST = CW'(FIRST);

    if (DIV < 2) begin : g_cfg_err
        $error("baudrate_clk_gen: DIV must be at least 2");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_first;
    logic          w_first_next;
    logic          r_baud_clk;
    logic          w_baud_clk_next;
    logic          r_baud_tick;
    logic          w_baud_tick_next;
    logic          w_tick_hit;

    // r_first marks the leading interval, which may be shorter than DIV.
    assign w_tick_hit = r_first ? (r_cnt == C_FIRST) : (r_cnt == C_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_first     <= 1'b1;
            r_baud_clk  <= 1'b0;
            r_baud_tick <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_first     <= w_first_next;
            r_baud_clk  <= w_baud_clk_next;
            r_baud_tick <= w_baud_tick_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_first_next     = r_first;
        w_baud_clk_next  = r_baud_clk;
        w_baud_tick_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next      = '0;
                w_first_next    = 1'b1;
                w_baud_clk_next = 1'b0;
                if (en) begin
                    w_state_next = S_RUN;
                    w_cnt_next   = CW'(1);
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_next    = S_IDLE;
                    w_cnt_next      = '0;
                    w_first_next    = 1'b1;
                    w_baud_clk_next = 1'b0;
                end else if (w_tick_hit) begin
                    w_cnt_next       = CW'(1);
                    w_first_next     = 1'b0;
                    w_baud_clk_next  = 1'b1;
                    w_baud_tick_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                    if (!r_first && (r_cnt == C_HALF)) begin
                        w_baud_clk_next = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_cnt_next      = '0;
                w_first_next    = 1'b1;
                w_baud_clk_next = 1'b0;
            end
        endcase
    end

    assign baud_clk  = r_baud_clk;
    assign baud_tick = r_baud_tick;

endmodule

// File: tb/tb_baudrate_clk_gen.sv
// Scoreboard bench for baudrate_clk_gen: default-rate instance (A) and a DIV=8 instance (B).
// Expected tick edges are queued at stimulus time; a negedge monitor pops and compares.
module tb_baudrate_clk_gen;

    localparam int A_CLK  = 125_000_000;
    localparam int A_BAUD = 115200;
    localparam int A_DIV  = (A_CLK + A_BAUD / 2) / A_BAUD;
    localparam int A_HALF = A_DIV / 2;
    localparam int B_CLK  = 16;
    localparam int B_BAUD = 2;
    localparam int B_DIV  = (B_CLK + B_BAUD / 2) / B_BAUD;
    localparam int B_HALF = B_DIV / 2;
`ifdef BAUDRATE_CLK_GEN_MIDBIT_EN
    localparam int A_FIRST = A_HALF;
    localparam int B_FIRST = B_HALF;
`else
    localparam int A_FIRST = A_DIV;
    localparam int B_FIRST = B_DIV;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en_a  = 1'b0;
    logic en_b  = 1'b0;
    logic baud_clk_a, baud_tick_a, baud_clk_b, baud_tick_b;

    baudrate_clk_gen #(.CLK_FREQ_HZ(A_CLK), .BAUD_RATE(A_BAUD)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .baud_clk(baud_clk_a), .baud_tick(baud_tick_a)
    );
    baudrate_clk_gen #(.CLK_FREQ_HZ(B_CLK), .BAUD_RATE(B_BAUD)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .baud_clk(baud_clk_b), .baud_tick(baud_tick_b)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_errors = 0;
    int qa[$];
    int qb[$];
    int win_e0[2];
    int win_d[2];
    bit win_on[2];
    int ticks_seen[2];

    function automatic int p_div(input int w);
        return (w == 0) ? A_DIV : B_DIV;
    endfunction
    function automatic int p_half(input int w);
        return (w == 0) ? A_HALF : B_HALF;
    endfunction
    function automatic int p_first(input int w);
        return (w == 0) ? A_FIRST : B_FIRST;
    endfunction

    // Reference: ticks at E0+FIRST+n*DIV inside the enable window, clock high for HALF edges from each tick.
    function automatic int exp_out(input int w, input int k, input bit want_tick);
        int s;
        int ph;
        if (!win_on[w]) return 0;
        s = win_e0[w] + p_first(w);
        if (k < s || k >= win_d[w]) return 0;
        ph = (k - s) % p_div(w);
        if (want_tick) return (ph == 0) ? 1 : 0;
        return (ph < p_half(w)) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic sb_pop(input int w, input int k);
        int e;
        ticks_seen[w]++;
        if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
            check(w == 0 ? "unexpected_tick_A" : "unexpected_tick_B", k, -1);
            return;
        end
        e = (w == 0) ? qa.pop_front() : qb.pop_front();
        $display("tick dut=%s edge=%0d expected_edge=%0d", w == 0 ? "A" : "B", k, e);
        check(w == 0 ? "tick_edge_A" : "tick_edge_B", k, e);
    endtask

    always @(negedge clk) begin
        check("baud_clk_A", baud_clk_a, exp_out(0, edge_cnt, 1'b0));
        check("baud_tick_A", baud_tick_a, exp_out(0, edge_cnt, 1'b1));
        check("baud_clk_B", baud_clk_b, exp_out(1, edge_cnt, 1'b0));
        check("baud_tick_B", baud_tick_b, exp_out(1, edge_cnt, 1'b1));
        if (baud_tick_a === 1'b1) sb_pop(0, edge_cnt);
        if (baud_tick_b === 1'b1) sb_pop(1, edge_cnt);
    end

    task automatic set_en(input int w, input logic v);
        if (w == 0) en_a = v;
        else en_b = v;
    endtask

    // Called #1 after a posedge; the next edge samples en=1 and the edge E0+dur samples en=0.
    task automatic begin_run(input int w, input int dur);
        int e0;
        e0 = edge_cnt + 1;
        set_en(w, 1'b1);
        win_e0[w] = e0;
        win_d[w]  = e0 + dur;
        win_on[w] = 1'b1;
        for (int t = e0 + p_first(w); t < e0 + dur; t += p_div(w)) begin
            if (w == 0) qa.push_back(t);
            else qb.push_back(t);
        end
    endtask

    task automatic run_for(input int w, input int dur);
        begin_run(w, dur);
        repeat (dur) @(posedge clk);
        #1 set_en(w, 1'b0);
        @(posedge clk);
        #1;
    endtask

    int seen0;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_clk_A", baud_clk_a, 0);
        check("reset_tick_A", baud_tick_a, 0);
        check("reset_clk_B", baud_clk_b, 0);
        check("reset_tick_B", baud_tick_b, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_for(0, 12000);

        seen0 = ticks_seen[0];
        run_for(0, A_FIRST + 9 * A_DIV + 1);
        check("frame_tick_count", ticks_seen[0] - seen0, 10);

        run_for(1, 6);
        run_for(1, B_FIRST + 2 * B_DIV + 4);
        run_for(1, 40);

        begin_run(0, A_FIRST + 3);
        repeat (A_FIRST + 2) @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_clk_A", baud_clk_a, exp_out(0, edge_cnt, 1'b0));
        rst_n = 1'b0;
        en_a = 1'b0;
        win_on[0] = 1'b0;
        qa.delete();
        #1;
        check("async_reset_clk_A", baud_clk_a, 0);
        check("async_reset_tick_A", baud_tick_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5000) @(posedge clk);
        #1;

        check("leftover_ticks_A", qa.size(), 0);
        check("leftover_ticks_B", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
